// File: rtl/entropy_bitstream_packer_if.sv
// rtl/entropy_bitstream_packer_if.sv - lane-beat input and byte-stream output bundle of the packer
interface entropy_bitstream_packer_if #(
   parameter int BITSTREAM_WIDTH = 8,
   parameter int NUM_LANES       = 3,
   parameter int BYTES_PER_LANE  = 5,
   parameter int FLAG_WIDTH      = 3
) ();
   logic                                                  in_valid;
   logic                                                  in_ready;
   logic [NUM_LANES*BYTES_PER_LANE*BITSTREAM_WIDTH-1:0]   in_bytes;
   logic [NUM_LANES*FLAG_WIDTH-1:0]                       in_flags;
   logic                                                  in_last;
   logic [BITSTREAM_WIDTH-1:0]                            out_byte;
   logic                                                  out_valid;
   logic                                                  out_ready;
   logic                                                  out_last;

   modport master (
      output in_valid, in_bytes, in_flags, in_last, out_ready,
      input  in_ready, out_byte, out_valid, out_last
   );

   modport slave (
      input  in_valid, in_bytes, in_flags, in_last, out_ready,
      output in_ready, out_byte, out_valid, out_last
   );
endinterface

// File: rtl/entropy_bitstream_packer.sv
// rtl/entropy_bitstream_packer.sv - compacts multi-lane byte groups into a FWFT byte FIFO
// and drains it as one byte stream with an end-of-stream marker.
module entropy_bitstream_packer #(
   parameter int BITSTREAM_WIDTH = 8,
   parameter int NUM_LANES       = 3,
   parameter int BYTES_PER_LANE  = 5,
   parameter int FLAG_WIDTH      = 3,
   parameter int FIFO_ADDR_WIDTH = 5
) (
   input  logic                       top_clk,
   input  logic                       top_reset_n,
   entropy_bitstream_packer_if.slave  bus,
   output logic                       done,
   output logic                       count_err,
   output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);
   localparam int W     = BITSTREAM_WIDTH;
   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int LW    = FIFO_ADDR_WIDTH + 1;
   localparam int FW    = FLAG_WIDTH;
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam int BEAT  = NUM_LANES * BYTES_PER_LANE;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d, wr_cnt;
   state_e        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          count_err_q, count_err_d;
   logic [FW-1:0] cnt [NUM_LANES];
   logic [LW-1:0] off [NUM_LANES];
   logic          accept, pop, out_valid;

   always_comb begin
      accept      = bus.in_valid & in_ready_q & (state_q == ST_RUN);
      out_valid   = (level_q != '0) & (state_q != ST_DONE);
      pop         = out_valid & bus.out_ready;
      count_err_d = count_err_q;
      wr_cnt      = '0;
      // Clamp each lane count and build the running write offset of each lane.
      for (int l = 0; l < NUM_LANES; l++) begin
         if (bus.in_flags[l*FW +: FW] > FW'(BYTES_PER_LANE)) begin
            cnt[l] = FW'(BYTES_PER_LANE);
            if (accept) count_err_d = 1'b1;
         end else begin
            cnt[l] = bus.in_flags[l*FW +: FW];
         end
         off[l] = wr_cnt;
         wr_cnt = wr_cnt + LW'(cnt[l]);
      end

      wr_ptr_d = accept ? wr_ptr_q + AW'(wr_cnt) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + (accept ? wr_cnt : '0) - LW'(pop);

      state_d = state_q;
      case (state_q)
         ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
         ST_DRAIN: if (level_d == '0) state_d = ST_DONE;
         default:  state_d = ST_DONE;
      endcase

      in_ready_d = (state_d == ST_RUN) && ((LW'(DEPTH) - level_d) >= LW'(BEAT));
   end

   always_ff @(posedge top_clk) begin
      if (!top_reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         state_q     <= ST_RUN;
         in_ready_q  <= 1'b0;
         count_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         count_err_q <= count_err_d;
      end
   end

   always_ff @(posedge top_clk) begin
      if (top_reset_n && accept) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            for (int b = 0; b < BYTES_PER_LANE; b++) begin
               if (FW'(b) < cnt[l])
                  mem_q[wr_ptr_q + AW'(off[l]) + AW'(b)] <= bus.in_bytes[(l*BYTES_PER_LANE+b)*W +: W];
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.out_byte  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.out_last  = (state_q == ST_DRAIN) & out_valid & (level_q == LW'(1));
   assign done          = (state_q == ST_DONE);
   assign count_err     = count_err_q;
   assign fifo_level    = level_q;
endmodule

// File: tb/tb_entropy_bitstream_packer.sv
// tb/tb_entropy_bitstream_packer.sv - scoreboard bench for the entropy bitstream packer
module tb_entropy_bitstream_packer;
   localparam int W   = 8;
   localparam int N   = 3;
   localparam int BPL = 5;
   localparam int FW  = 3;
   localparam int AW  = 5;
   localparam int DW  = N * BPL * W;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          done, count_err;
   logic [AW:0]   fifo_level;
   int            n_tests = 0;
   int            n_fail = 0;
   int            last_seen = 0;
   exp_t          sb[$];

   always #5 clk = ~clk;

   entropy_bitstream_packer_if #(.BITSTREAM_WIDTH(W), .NUM_LANES(N), .BYTES_PER_LANE(BPL),
                                 .FLAG_WIDTH(FW)) bus ();

   entropy_bitstream_packer #(.BITSTREAM_WIDTH(W), .NUM_LANES(N), .BYTES_PER_LANE(BPL),
                              .FLAG_WIDTH(FW), .FIFO_ADDR_WIDTH(AW)) dut (
      .top_clk     (clk),
      .top_reset_n (rst_n),
      .bus         (bus),
      .done        (done),
      .count_err   (count_err),
      .fifo_level  (fifo_level)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_last) last_seen++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_byte", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_byte", {24'd0, bus.out_byte}, {24'd0, e.data});
               check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < N * BPL; i++) d[i*W +: W] = W'($urandom_range(0, 255));
      return d;
   endfunction

   task automatic send_beat(input logic [DW-1:0] data, input logic [N*FW-1:0] flags, input logic last);
      int waited;
      int f;
      exp_t e;
      waited = 0;
      for (int l = 0; l < N; l++) begin
         f = int'(flags[l*FW +: FW]);
         if (f > BPL) f = BPL;
         for (int b = 0; b < f; b++) begin
            e.data = data[(l*BPL+b)*W +: W];
            e.last = 1'b0;
            sb.push_back(e);
         end
      end
      if (last && sb.size() > 0) sb[sb.size()-1].last = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bytes = data;
      bus.in_flags = flags;
      bus.in_last  = last;
      while (!bus.in_ready && waited < 200) begin
         tick(1);
         waited++;
      end
      check("in_ready_wait", {31'd0, bus.in_ready}, 1);
      tick(1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while ((sb.size() != 0 || fifo_level != 0) && waited < 300) begin
         tick(1);
         waited++;
      end
      check("drain_done", {31'd0, (sb.size() == 0 && fifo_level == 0)}, 1);
   endtask

   initial begin
      logic [DW-1:0] d;
      bus.in_valid  = 1'b0;
      bus.in_bytes  = '0;
      bus.in_flags  = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset held with a valid beat present
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bytes = rand_data();
      bus.in_flags = {3'd1, 3'd1, 3'd1};
      tick(3);
      check("rst_in_ready", {31'd0, bus.in_ready}, 0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_out_last", {31'd0, bus.out_last}, 0);
      check("rst_out_byte", {24'd0, bus.out_byte}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_count_err", {31'd0, count_err}, 0);
      check("rst_level", {26'd0, fifo_level}, 0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      tick(1);
      check("rel_in_ready", {31'd0, bus.in_ready}, 1);
      check("rel_level", {26'd0, fifo_level}, 0);

      // Compaction with a skipped lane and ignored tail bytes
      bus.out_ready = 1'b1;
      d = rand_data();
      d[0*W +: W] = 8'hA0;
      d[1*W +: W] = 8'hA1;
      d[10*W +: W] = 8'hC0;
      d[11*W +: W] = 8'hC1;
      d[12*W +: W] = 8'hC2;
      send_beat(d, {3'd3, 3'd0, 3'd2}, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("t2_stream_valid", {31'd0, bus.out_valid}, 1);
         tick(1);
      end
      check("t2_stream_end", {31'd0, bus.out_valid}, 0);

      // Backpressure: fill until in_ready drops, then drain in order
      bus.out_ready = 1'b0;
      send_beat(rand_data(), {3'd5, 3'd5, 3'd5}, 1'b0);
      check("t3_level15", {26'd0, fifo_level}, 15);
      check("t3_ready15", {31'd0, bus.in_ready}, 1);
      send_beat(rand_data(), {3'd5, 3'd5, 3'd5}, 1'b0);
      check("t3_level30", {26'd0, fifo_level}, 30);
      check("t3_ready30", {31'd0, bus.in_ready}, 0);
      tick(3);
      check("t3_hold_valid", {31'd0, bus.out_valid}, 1);
      check("t3_hold_byte", {24'd0, bus.out_byte}, {24'd0, sb[0].data});
      check("t3_still_blocked", {31'd0, bus.in_ready}, 0);
      bus.out_ready = 1'b1;
      send_beat(rand_data(), {3'd5, 3'd5, 3'd5}, 1'b0);
      wait_drain();

      // End of stream with a single byte
      d = rand_data();
      d[0 +: W] = 8'h5A;
      send_beat(d, {3'd0, 3'd0, 3'd1}, 1'b1);
      check("t4_out_last", {31'd0, bus.out_last}, 1);
      check("t4_byte", {24'd0, bus.out_byte}, 32'h5A);
      tick(1);
      check("t4_done", {31'd0, done}, 1);
      check("t4_valid_off", {31'd0, bus.out_valid}, 0);
      bus.in_valid = 1'b1;
      bus.in_bytes = rand_data();
      bus.in_flags = {3'd5, 3'd5, 3'd5};
      tick(5);
      check("t4_done_held", {31'd0, done}, 1);
      check("t4_ignore_ready", {31'd0, bus.in_ready}, 0);
      check("t4_ignore_level", {26'd0, fifo_level}, 0);
      bus.in_valid = 1'b0;

      // Oversized flag and an all-zero final beat
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      send_beat(rand_data(), {3'd0, 3'd7, 3'd0}, 1'b0);
      check("t5_count_err", {31'd0, count_err}, 1);
      wait_drain();
      send_beat(rand_data(), {3'd1, 3'd1, 3'd1}, 1'b0);
      wait_drain();
      check("t5_err_sticky", {31'd0, count_err}, 1);
      last_seen = 0;
      send_beat(rand_data(), {3'd0, 3'd0, 3'd0}, 1'b1);
      check("t5_not_done_yet", {31'd0, done}, 0);
      tick(1);
      check("t5_done", {31'd0, done}, 1);
      tick(2);
      check("t5_no_out_last", last_seen, 0);

      // Reset while draining
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      send_beat(rand_data(), {3'd0, 3'd4, 3'd5}, 1'b1);
      check("t6_level9", {26'd0, fifo_level}, 9);
      check("t6_not_done", {31'd0, done}, 0);
      rst_n = 1'b0;
      sb.delete();
      tick(1);
      check("t6_rst_level", {26'd0, fifo_level}, 0);
      check("t6_rst_done", {31'd0, done}, 0);
      check("t6_rst_valid", {31'd0, bus.out_valid}, 0);
      check("t6_rst_err", {31'd0, count_err}, 0);
      rst_n = 1'b1;
      tick(1);
      check("t6_run_ready", {31'd0, bus.in_ready}, 1);
      bus.out_ready = 1'b1;
      send_beat(rand_data(), {3'd2, 3'd0, 3'd0}, 1'b0);
      wait_drain();
      check("t6_run_not_done", {31'd0, done}, 0);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
